// File: rtl/ram_pkg.sv
// Shared types, defaults and parameter legality rule for the pipelined backing-store RAM.
// No logic of its own; imported by pipelined_ram and its response FIFO.
package ram_pkg;

    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_ADDR_BITS  = 12;
    localparam int DEF_TAG_WIDTH  = 8;

    typedef struct packed {
        logic                          rw;
        logic [DEF_DATA_WIDTH/8-1:0]   byteen;
        logic [DEF_ADDR_BITS-1:0]      addr;
        logic [DEF_DATA_WIDTH-1:0]     data;
        logic [DEF_TAG_WIDTH-1:0]      tag;
    } ram_req_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]     data;
        logic [DEF_TAG_WIDTH-1:0]      tag;
    } ram_rsp_t;

    // RSP_DEPTH must cover the whole read pipeline, otherwise credits could not keep it full.
    function automatic bit ram_cfg_ok(input int dw, input int aw, input int ab,
                                      input int rl, input int rd);
        return (dw > 0) && (dw % 8 == 0) && (ab >= 1) && (ab <= aw) &&
               (rl >= 1) && (rl <= 4) && (rd >= rl) && ((rd & (rd - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Response queue: registered full/empty, head shown in the same cycle it is written behind.
// Push and pop may coincide in any state; pushing while full without a pop is a protocol error.
module ram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_cnt_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop  = i_pop && !r_empty;
    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Storage is not reset, so an empty queue presents zeros rather than stale contents.
    assign o_pop_dat = r_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && r_full && !i_pop));

endmodule

// File: rtl/pipelined_ram.sv
// Byte-enabled RAM with credit-limited request channel; read data valid READ_LATENCY cycles after accept.
// Requests stall only when RSP_DEPTH responses are in flight or queued, so response back-pressure never drops data.
module pipelined_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 32,
    parameter int ADDR_BITS    = 12,
    parameter int TAG_WIDTH    = 8,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4,
    parameter int WRITE_RSP    = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              mem_req_valid_i,
    input  logic                              mem_req_rw_i,
    input  logic [DATA_WIDTH/8-1:0]           mem_req_byteen_i,
    input  logic [ADDR_WIDTH-1:0]             mem_req_addr_i,
    input  logic [DATA_WIDTH-1:0]             mem_req_data_i,
    input  logic [TAG_WIDTH-1:0]              mem_req_tag_i,
    output logic                              mem_req_ready_o,
    output logic                              mem_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]             mem_rsp_data_o,
    output logic [TAG_WIDTH-1:0]              mem_rsp_tag_o,
    input  logic                              mem_rsp_ready_i,
    output logic [$clog2(RSP_DEPTH+1)-1:0]    outstanding_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_BITS;
    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam int STAGES = READ_LATENCY - 1;

    generate
        if (!ram_cfg_ok(DATA_WIDTH, ADDR_WIDTH, ADDR_BITS, READ_LATENCY, RSP_DEPTH)) begin : g_bad_cfg
            $error("pipelined_ram: illegal parameter combination");
        end
        if (ADDR_WIDTH > ADDR_BITS) begin : g_addr_hi
            logic w_unused_addr;
            assign w_unused_addr = ^mem_req_addr_i[ADDR_WIDTH-1:ADDR_BITS];
        end
    endgenerate

    // Same layout as ram_req_t/ram_rsp_t, sized by this instance's parameters.
    typedef struct packed {
        logic                   rw;
        logic [NBYTES-1:0]      byteen;
        logic [ADDR_BITS-1:0]   addr;
        logic [DATA_WIDTH-1:0]  data;
        logic [TAG_WIDTH-1:0]   tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [TAG_WIDTH-1:0]   tag;
    } rsp_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_live;
    logic [CW-1:0]         r_outstanding;
    req_t                  w_req;
    logic                  w_acc;
    logic                  w_credit;
    logic                  w_rsp_hs;
    logic                  w_s0_vld;
    rsp_t                  w_s0_dat;
    logic                  w_push_vld;
    rsp_t                  w_push_dat;
    rsp_t                  w_head;
    logic                  w_fifo_empty;
    logic                  w_unused_fifo_full;

    assign w_req = '{rw:     mem_req_rw_i,
                     byteen: mem_req_byteen_i,
                     addr:   mem_req_addr_i[ADDR_BITS-1:0],
                     data:   mem_req_data_i,
                     tag:    mem_req_tag_i};

    // r_live keeps ready low through reset without a path from rst_ni to ready.
    assign mem_req_ready_o = r_live && (r_outstanding < CW'(RSP_DEPTH));
    assign w_acc           = mem_req_valid_i && mem_req_ready_o;
    assign w_credit        = w_acc && (!w_req.rw || (WRITE_RSP != 0));
    assign w_rsp_hs        = mem_rsp_valid_o && mem_rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_live        <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_credit && !w_rsp_hs) begin
                r_outstanding <= r_outstanding + CW'(1);
            end else if (!w_credit && w_rsp_hs) begin
                r_outstanding <= r_outstanding - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_acc && w_req.rw) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_req.byteen[b]) begin
                    r_mem[w_req.addr][8*b +: 8] <= w_req.data[8*b +: 8];
                end
            end
        end
    end

    assign w_s0_vld = w_credit;

    always_comb begin
        w_s0_dat     = '0;
        w_s0_dat.tag = w_req.tag;
        if (!w_req.rw) begin
            w_s0_dat.data = r_mem[w_req.addr];
        end
    end

    generate
        if (STAGES == 0) begin : g_no_pipe
            assign w_push_vld = w_s0_vld;
            assign w_push_dat = w_s0_dat;
        end else begin : g_pipe
            logic r_vld [STAGES];
            rsp_t r_dat [STAGES];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_vld[i] <= 1'b0;
                        r_dat[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= w_s0_vld;
                    r_dat[0] <= w_s0_dat;
                    for (int i = 1; i < STAGES; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign w_push_vld = r_vld[STAGES-1];
            assign w_push_dat = r_dat[STAGES-1];
        end
    endgenerate

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_push     (w_push_vld),
        .i_push_dat (w_push_dat),
        .i_pop      (w_rsp_hs),
        .o_pop_dat  (w_head),
        .o_full     (w_unused_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign mem_rsp_valid_o = !w_fifo_empty;
    assign mem_rsp_data_o  = w_head.data;
    assign mem_rsp_tag_o   = w_head.tag;
    assign outstanding_o   = r_outstanding;

    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_outstanding <= CW'(RSP_DEPTH));

endmodule

// File: doc/pipelined_ram.md
# pipelined_ram

- Parametrised, pipelined, byte-enabled RAM model with a valid/ready request channel and an in-order valid/ready response channel.
- Accepts one request per cycle, returns read data after a fixed configurable latency, and optionally acknowledges writes.
- Limits outstanding transactions by credit so responses are never dropped under response back-pressure.
- Sits in the GPU memory subsystem as the simulation/FPGA backing store behind the cache memory port.

## Interface
- DATA_WIDTH, 512, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, width of the request address port.
- ADDR_BITS, 12, number of address bits used; depth = 2**ADDR_BITS words; upper address bits are ignored.
- TAG_WIDTH, 8, request/response tag width.
- READ_LATENCY, 2, cycles from read acceptance to earliest response valid; legal range 1..4.
- RSP_DEPTH, 4, maximum outstanding responses; power of 2, at least READ_LATENCY.
- WRITE_RSP, 0, when 1 each accepted write returns a response; response data is '0.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mem_req_valid_i  in  1  request valid.
- mem_req_rw_i  in  1  1 = write, 0 = read.
- mem_req_byteen_i  in  DATA_WIDTH/8  write byte enables.
- mem_req_addr_i  in  ADDR_WIDTH  word address.
- mem_req_data_i  in  DATA_WIDTH  write data.
- mem_req_tag_i  in  TAG_WIDTH  request tag.
- mem_req_ready_o  out  1  request accepted when valid && ready.
- mem_rsp_valid_o  out  1  response valid.
- mem_rsp_data_o  out  DATA_WIDTH  read data.
- mem_rsp_tag_o  out  TAG_WIDTH  tag of the originating request.
- mem_rsp_ready_i  in  1  response consumed when valid && ready.
- outstanding_o  out  $clog2(RSP_DEPTH+1)  in-flight plus queued responses, for debug.

## Operation
- **Reset values:**
  - Array contents are not reset.
  - mem_req_ready_o=0 while rst_ni=0 and 1 from the first cycle after release.
  - mem_rsp_valid_o=0, mem_rsp_data_o='0, mem_rsp_tag_o='0.
  - outstanding_o=0.
  - Pipeline and FIFO are emptied.
  - Reset mid-operation discards all in-flight responses; writes already accepted remain in the array.
- **Credits:**
  - Credit counter counts responses in the pipeline plus responses in the FIFO.
  - mem_req_ready_o = (outstanding_o < RSP_DEPTH).
  - A write consumes no credit when WRITE_RSP=0.
  - When WRITE_RSP=0, mem_req_ready_o is still driven by the credit counter, so a write is stalled while credits are exhausted.
- **Counter update:**
  - +1 on a credit-consuming accept.
  - −1 on a response handshake.
  - Unchanged when both occur in the same cycle.
  - Never exceeds RSP_DEPTH and never underflows.
- **Write:**
  - Enabled bytes of mem_array[addr[ADDR_BITS-1:0]] update at the accept edge.
  - Bytes with byteen=0 are untouched; byteen='0 is a legal no-op that still acks if WRITE_RSP=1.
- **Read:**
  - Array is sampled at the accept edge.
  - Data, tag and valid travel through READ_LATENCY-1 register stages, then enter the response FIFO.
- **Ordering:**
  - A read observes every write accepted in an earlier cycle.
  - At most one request is accepted per cycle, so there is no same-cycle read/write hazard.
  - Responses return strictly in acceptance order, reads and write-acks interleaved.
- **Response channel:**
  - mem_rsp_valid_o = FIFO not empty.
  - Data and tag are held stable while valid && !ready.
  - Pop on handshake.
- **FIFO boundaries:**
  - Push and pop in the same cycle are legal in every state, including full and empty.
  - Overflow is impossible by construction of the credit rule; an assertion checks it.
  - Pointers wrap modulo RSP_DEPTH.

## Timing
- Request accepted in cycle N produces mem_rsp_valid_o=1 in cycle N+READ_LATENCY at the earliest, if the FIFO ahead of it is empty.
- Throughput is one request per cycle while mem_rsp_ready_i=1.
- With mem_rsp_ready_i held low, exactly RSP_DEPTH credit-consuming requests are accepted, then ready drops.
- Ready rises in the cycle after the first response handshake.
- mem_req_ready_o depends only on registered state; there is no combinational path from any input.

## Structure
- **ram_pkg:**
  - typedef for request payload struct {rw, byteen, addr, data, tag}.
  - typedef for response payload struct {data, tag}.
  - Parameter legality checks as elaborate-time assertions.
- **Sub-module ram_rsp_fifo:**
  - Parametrised depth and payload width.
  - Synchronous push/pop, registered full/empty.
  - Asynchronous active-low reset.
  - Reused for the response queue.

## Test plan
- Write addr 0x010, data all 0xAA, byteen all-ones; then read 0x010 with tag 0x3 -> response valid 2 cycles after read accept, data all 0xAA, tag 0x3.
- Write 0x020 all 0x11; write 0x020 all 0x22 with byteen=0x...0001 -> read returns 0x11 in all bytes except byte0=0x22.
- Back-to-back reads tags 1..8 with mem_rsp_ready_i=1 -> 8 responses on consecutive cycles, tags 1..8 in order, ready never drops.
- mem_rsp_ready_i=0, issue 6 reads with RSP_DEPTH=4 -> exactly 4 accepted, outstanding_o=4, ready=0; raise rsp_ready -> 4 responses in order, remaining 2 accepted afterwards.
- WRITE_RSP=1, interleave write tag 5 and read tag 6 -> responses tag 5 (data '0) then tag 6; WRITE_RSP=0 -> only tag 6 response.
- Assert rst_ni low with 3 reads in flight -> rsp_valid=0 and outstanding_o=0 immediately; after release, a read returns data written before the reset.
